iris_axil_master: RTL and testbench

- Upstream stage of the Iris memory slave.
- Converts the core's single-beat load/store request handshake into AXI-Lite write (AW/W/B) and read (AR/R) transactions.
- One transaction outstanding at a time.
- Returns read data and the response status to the core on a valid/ready response channel.

---
 rtl/iris_axil_master.sv | 206 ++++++++++++++++++++
 tb/tb_iris_axil_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iris_axil_master.sv
// iris_axil_master: single-outstanding core load/store to AXI-Lite bridge.
// A request is accepted in IDLE, issued on AW/W or AR, and its response is
// returned to the core on rsp_valid/rsp_ready before the next is accepted.
// Optional feature macro: IRIS_AXIL_TIMEOUT_EN adds a per-transaction
// watchdog (TIMEOUT_CYCLES) and the sticky tmo_flag output.
module iris_axil_master #(
  parameter int DATA_WIDTH     = 24,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [2:0]              axi_awprot,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  input  logic [1:0]              axi_bresp,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [2:0]              axi_arprot,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp
`ifdef IRIS_AXIL_TIMEOUT_EN
  ,
  output logic                    tmo_flag
`endif
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         strb_q;
  logic                  aw_done, w_done;
  logic                  aw_hs, w_hs, aw_fin, w_fin;

  // Only the error bit of the AXI response codes is reported to the core.
  logic unused_resp;
  assign unused_resp = ^{axi_bresp[0], axi_rresp[0]};

  assign req_ready  = (state == IDLE);
  assign axi_awaddr = addr_q;
  assign axi_araddr = addr_q;
  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = strb_q;
  assign axi_awprot = 3'b000;
  assign axi_arprot = 3'b000;

  // AW and W complete independently; a channel is finished once its
  // handshake happened now or in an earlier cycle.
  assign aw_hs  = axi_awvalid & axi_awready;
  assign w_hs   = axi_wvalid & axi_wready;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

`ifdef IRIS_AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;
  logic          waiting, advance, tmo_fire;

  assign waiting  = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_DATA);
  // A transaction that makes its final handshake in the limit cycle wins
  // over the watchdog so the slave is never left with a dangling beat.
  assign advance  = ((state == WR_REQ)  && aw_fin && w_fin) ||
                    ((state == WR_RESP) && axi_bvalid) ||
                    ((state == RD_REQ)  && axi_arready) ||
                    ((state == RD_DATA) && axi_rvalid);
  assign tmo_fire = waiting && !advance && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared while idle (so it starts at zero on entry to a
  // request state) and counts every cycle spent waiting on the slave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tmo_cnt <= '0;
    else if (!waiting)   tmo_cnt <= '0;
    else if (!tmo_fire)  tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  // Transaction FSM with registered AXI and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
`ifdef IRIS_AXIL_TIMEOUT_EN
      tmo_flag    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            strb_q  <= req_be;
            if (req_we) begin
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= WR_REQ;
            end else begin
              axi_arvalid <= 1'b1;
              state       <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) axi_awvalid <= 1'b0;
          if (w_hs)  axi_wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            axi_bready <= 1'b1;
            state      <= WR_RESP;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        WR_RESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= axi_bresp[1];
            rsp_valid  <= 1'b1;
            state      <= RSP;
          end
        end
        RD_REQ: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            rsp_rdata  <= axi_rdata;
            rsp_err    <= axi_rresp[1];
            rsp_valid  <= 1'b1;
            state      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef IRIS_AXIL_TIMEOUT_EN
      // Abandon the slave and report an error response to the core.
      if (tmo_fire) begin
        axi_awvalid <= 1'b0;
        axi_wvalid  <= 1'b0;
        axi_bready  <= 1'b0;
        axi_arvalid <= 1'b0;
        axi_rready  <= 1'b0;
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_valid   <= 1'b1;
        tmo_flag    <= 1'b1;
        state       <= RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_iris_axil_master.sv
// Testbench for iris_axil_master: behavioural AXI-Lite slave with
// per-channel latency knobs, plus a request-level memory model.
module tb_iris_axil_master;
  localparam int DW = 24, AW = 16, SW = 3, TMO = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req_valid = 0, req_ready, req_we = 0, rsp_valid, rsp_ready = 0, rsp_err;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, rsp_rdata;
  logic [SW-1:0] req_be = '0;
  logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic arvalid, arready = 0, rvalid = 0, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [DW-1:0] wdata, rdata = '0;
  logic [SW-1:0] wstrb;
  logic [1:0] bresp = 0, rresp = 0;
  logic tmo_flag;

  iris_axil_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awprot(awprot),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arprot(arprot),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp)
`ifdef IRIS_AXIL_TIMEOUT_EN
    , .tmo_flag(tmo_flag)
`endif
  );
`ifndef IRIS_AXIL_TIMEOUT_EN
  assign tmo_flag = 1'b0;
`endif

  int passed = 0, total = 0;

  // slave knobs
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0] bresp_k = 0, rresp_k = 0;
  logic r_ov = 0;
  logic [DW-1:0] r_ov_data = '0;

  // slave state and observations
  logic [DW-1:0] smem [16];
  logic [DW-1:0] mmem [16];
  logic aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
  logic [DW-1:0] cap_wdata = '0;
  logic [SW-1:0] cap_wstrb = '0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, cyc = 0;
  int aw_hi = 0, w_hi = 0, ar_hi = 0, aw_hs_cyc = 0, w_hs_cyc = 0, bready_cyc = -1, stab_err = 0;
  logic p_awv = 0, p_wv = 0, p_arv = 0;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_wstrb;

  // Edge monitor: handshakes, slave memory writes, AXI stability.
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; p_awv = 0; p_wv = 0; p_arv = 0;
    end else begin
      if (p_awv && (!awvalid || awaddr !== p_awaddr)) stab_err++;
      if (p_wv && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) stab_err++;
      if (p_arv && (!arvalid || araddr !== p_araddr)) stab_err++;
      p_awv = awvalid && !awready; p_awaddr = awaddr;
      p_wv = wvalid && !wready; p_wdata = wdata; p_wstrb = wstrb;
      p_arv = arvalid && !arready; p_araddr = araddr;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (arvalid) ar_hi++;
      if (bready && bready_cyc < 0) bready_cyc = cyc;
      if (bvalid && bready) b_pend = 0;
      if (rvalid && rready) r_pend = 0;
      if (awvalid && awready) begin aw_got = 1; cap_awaddr = awaddr; aw_hs_cyc = cyc; end
      if (wvalid && wready) begin w_got = 1; cap_wdata = wdata; cap_wstrb = wstrb; w_hs_cyc = cyc; end
      if (aw_got && w_got) begin
        for (int b = 0; b < SW; b++)
          if (cap_wstrb[b]) smem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
        aw_got = 0; w_got = 0; b_pend = 1;
      end
      if (arvalid && arready) begin cap_araddr = araddr; r_pend = 1; end
    end
    cyc++;
  end

  // Slave drive on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (awvalid) begin awready = (aw_cnt >= aw_lat); aw_cnt++; end else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_lat); w_cnt++; end else begin wready = 0; w_cnt = 0; end
      if (arvalid) begin arready = (ar_cnt >= ar_lat); ar_cnt++; end else begin arready = 0; ar_cnt = 0; end
      if (b_pend) begin bvalid = (b_cnt >= b_lat); bresp = bresp_k; b_cnt++; end else begin bvalid = 0; b_cnt = 0; end
      if (r_pend) begin
        rvalid = (r_cnt >= r_lat); rresp = rresp_k; r_cnt++;
        rdata = r_ov ? r_ov_data : smem[cap_araddr[5:2]];
      end else begin rvalid = 0; r_cnt = 0; end
    end
  end

  int hold_bad = 0;
  logic post_ready = 0, hs_ready = 0;

  // Issue one request and complete its response after 'hold' low rsp_ready cycles.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] be, input int hold,
                        output logic [DW-1:0] rd, output logic er, output int lat, output logic ok);
    int n = 0;
    aw_hi = 0; w_hi = 0; ar_hi = 0; bready_cyc = -1; hold_bad = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; lat = 1;
    while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
    ok = rsp_valid; rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0) hold_bad++;
      @(negedge clk);
    end
    rsp_ready = 1; hs_ready = req_ready;
    @(negedge clk);
    rsp_ready = 0; post_ready = req_ready;
  endtask

  task automatic test_reset();
    #12;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready); else passed++;
    total++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err} !== 7'b0)
      $display("FAIL reset_valids: got %b expected 0", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err}); else passed++;
    total++; if ({awaddr, wdata, wstrb, rsp_rdata} !== '0)
      $display("FAIL reset_regs: got %h %h %h %h expected 0", awaddr, wdata, wstrb, rsp_rdata); else passed++;
    total++; if ({awprot, arprot} !== 6'b0) $display("FAIL prot: got %b expected 0", {awprot, arprot}); else passed++;
    total++; if (tmo_flag !== 1'b0) $display("FAIL reset_tmo: got %b expected 0", tmo_flag); else passed++;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_store();
    logic [DW-1:0] rd; logic er, ok; int lat;
    aw_lat = 0; w_lat = 0; b_lat = 0; bresp_k = 2'b00;
    do_req(1'b1, 16'h0040, 24'hA5B6C7, 3'b111, 0, rd, er, lat, ok);
    total++; if (lat !== 3) $display("FAIL store_latency: got %0d expected 3", lat); else passed++;
    total++; if ({er, rd} !== 25'b0) $display("FAIL store_rsp: got err %b data %h expected 0 0", er, rd); else passed++;
    total++; if (cap_awaddr !== 16'h0040 || cap_wdata !== 24'hA5B6C7 || cap_wstrb !== 3'b111)
      $display("FAIL store_axi: got %h %h %b expected 0040 a5b6c7 111", cap_awaddr, cap_wdata, cap_wstrb); else passed++;
    total++; if (aw_hi !== 1 || w_hi !== 1) $display("FAIL store_awv_cycles: got %0d %0d expected 1 1", aw_hi, w_hi); else passed++;
    do_req(1'b1, 16'h0044, 24'h123456, 3'b000, 0, rd, er, lat, ok);
    total++; if (cap_wstrb !== 3'b000 || cap_awaddr !== 16'h0044 || !ok)
      $display("FAIL store_be0: got strb %b addr %h ok %b expected 000 0044 1", cap_wstrb, cap_awaddr, ok); else passed++;
    ar_lat = 0; r_lat = 0; r_ov = 1; r_ov_data = 24'h5A5A5A; rresp_k = 2'b01;
    do_req(1'b0, 16'h0008, 24'h0, 3'b0, 0, rd, er, lat, ok);
    total++; if (lat !== 3 || rd !== 24'h5A5A5A || er !== 1'b0)
      $display("FAIL load_fast: got lat %0d data %h err %b expected 3 5a5a5a 0", lat, rd, er); else passed++;
  endtask

  task automatic test_load_wait();
    logic [DW-1:0] rd; logic er, ok; int lat;
    ar_lat = 2; r_lat = 5; r_ov = 1; r_ov_data = 24'h00FF00; rresp_k = 2'b00;
    do_req(1'b0, 16'h1234, 24'h0, 3'b0, 0, rd, er, lat, ok);
    total++; if (rd !== 24'h00FF00 || er !== 1'b0 || !ok) $display("FAIL load_wait_rsp: got %h err %b expected 00ff00 0", rd, er); else passed++;
    total++; if (cap_araddr !== 16'h1234) $display("FAIL load_araddr: got %h expected 1234", cap_araddr); else passed++;
    total++; if (ar_hi !== 3) $display("FAIL load_arvalid_cycles: got %0d expected 3", ar_hi); else passed++;
    total++; if (lat !== 10) $display("FAIL load_wait_latency: got %0d expected 10", lat); else passed++;
    ar_lat = 0; r_lat = 0; r_ov = 0;
  endtask

  task automatic test_aw_before_w();
    logic [DW-1:0] rd; logic er, ok; int lat;
    aw_lat = 0; w_lat = 3; b_lat = 0; bresp_k = 2'b00;
    do_req(1'b1, 16'h0010, 24'h010203, 3'b101, 0, rd, er, lat, ok);
    total++; if (aw_hi !== 1 || w_hi !== 4) $display("FAIL split_valid_cycles: got aw %0d w %0d expected 1 4", aw_hi, w_hi); else passed++;
    total++; if (w_hs_cyc - aw_hs_cyc !== 3) $display("FAIL split_hs_gap: got %0d expected 3", w_hs_cyc - aw_hs_cyc); else passed++;
    total++; if (bready_cyc !== w_hs_cyc + 1) $display("FAIL split_bready: got %0d expected %0d", bready_cyc, w_hs_cyc + 1); else passed++;
    total++; if (!ok || er !== 1'b0) $display("FAIL split_rsp: got ok %b err %b expected 1 0", ok, er); else passed++;
    w_lat = 0;
  endtask

  task automatic test_slverr_hold();
    logic [DW-1:0] rd; logic er, ok; int lat;
    r_ov = 1; r_ov_data = 24'hBEEF01; rresp_k = 2'b10;
    do_req(1'b0, 16'h0020, 24'h0, 3'b0, 4, rd, er, lat, ok);
    total++; if (er !== 1'b1 || rd !== 24'hBEEF01) $display("FAIL slverr_rsp: got err %b data %h expected 1 beef01", er, rd); else passed++;
    total++; if (hold_bad !== 0) $display("FAIL slverr_hold: got %0d unstable cycles expected 0", hold_bad); else passed++;
    total++; if (hs_ready !== 1'b0) $display("FAIL slverr_ready_in_hs: got %b expected 0", hs_ready); else passed++;
    total++; if (post_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL slverr_after_hs: got ready %b valid %b expected 1 0", post_ready, rsp_valid); else passed++;
    r_ov = 0; rresp_k = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic er, ok; int lat; int n = 0;
    b_lat = 50;
    @(negedge clk); req_valid = 1; req_we = 1; req_addr = 16'h0030; req_wdata = 24'hCAFE00; req_be = 3'b111;
    @(posedge clk); @(negedge clk); req_valid = 0;
    while (!bready && n < 20) begin @(negedge clk); n++; end
    total++; if (bready !== 1'b1) $display("FAIL mid_reach_wr_resp: got %b expected 1", bready); else passed++;
    #1 rst_n = 0;
    #1;
    total++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err} !== 7'b0 || req_ready !== 1'b1)
      $display("FAIL mid_reset_outputs: got %b ready %b expected 0 1", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err}, req_ready); else passed++;
    total++; if ({awaddr, wdata, wstrb} !== '0) $display("FAIL mid_reset_regs: got %h %h %h expected 0", awaddr, wdata, wstrb); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1; b_lat = 0;
    repeat (3) @(negedge clk);
    total++; if (rsp_valid !== 1'b0) $display("FAIL mid_no_rsp: got %b expected 0", rsp_valid); else passed++;
    do_req(1'b1, 16'h0034, 24'h777777, 3'b011, 0, rd, er, lat, ok);
    total++; if (!ok || lat !== 3 || er !== 1'b0 || cap_wdata !== 24'h777777)
      $display("FAIL mid_after_reset: got ok %b lat %0d err %b data %h expected 1 3 0 777777", ok, lat, er, cap_wdata); else passed++;
  endtask

  task automatic test_random();
    logic [DW-1:0] rd, d, exp_d; logic er, ok, we, exp_e; int lat, idx; logic [SW-1:0] be; logic [AW-1:0] a;
    for (int i = 0; i < 16; i++) begin smem[i] = '0; mmem[i] = '0; end
    stab_err = 0; r_ov = 0;
    for (int t = 0; t < 40; t++) begin
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      bresp_k = 2'($urandom_range(0, 3)); rresp_k = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 15);
      a = AW'(idx * 4); d = DW'($urandom); be = SW'($urandom_range(0, 7));
      if (we) begin
        for (int b = 0; b < SW; b++) if (be[b]) mmem[idx][8*b +: 8] = d[8*b +: 8];
        exp_d = '0; exp_e = bresp_k[1];
      end else begin
        exp_d = mmem[idx]; exp_e = rresp_k[1];
      end
      do_req(we, a, d, be, $urandom_range(0, 2), rd, er, lat, ok);
      total++; if (!ok || rd !== exp_d || er !== exp_e)
        $display("FAIL random_%0d: got ok %b data %h err %b expected 1 %h %b", t, ok, rd, er, exp_d, exp_e); else passed++;
      if (we) begin
        total++; if (cap_awaddr !== a || cap_wdata !== d || cap_wstrb !== be)
          $display("FAIL random_axi_%0d: got %h %h %b expected %h %h %b", t, cap_awaddr, cap_wdata, cap_wstrb, a, d, be); else passed++;
      end
    end
    total++; if (stab_err !== 0) $display("FAIL axi_stability: got %0d violations expected 0", stab_err); else passed++;
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
  endtask

`ifdef IRIS_AXIL_TIMEOUT_EN
  task automatic test_timeout();
    logic [DW-1:0] rd; logic er, ok; int lat;
    ar_lat = 100000;
    do_req(1'b0, 16'h0050, 24'h0, 3'b0, 0, rd, er, lat, ok);
    total++; if (ar_hi !== TMO) $display("FAIL tmo_arvalid_cycles: got %0d expected %0d", ar_hi, TMO); else passed++;
    total++; if (!ok || er !== 1'b1 || rd !== '0) $display("FAIL tmo_rsp: got ok %b err %b data %h expected 1 1 0", ok, er, rd); else passed++;
    total++; if (tmo_flag !== 1'b1) $display("FAIL tmo_flag_set: got %b expected 1", tmo_flag); else passed++;
    ar_lat = 0; r_ov = 1; r_ov_data = 24'h000111; rresp_k = 2'b00;
    do_req(1'b0, 16'h0054, 24'h0, 3'b0, 0, rd, er, lat, ok);
    total++; if (tmo_flag !== 1'b1 || er !== 1'b0 || rd !== 24'h000111)
      $display("FAIL tmo_sticky: got flag %b err %b data %h expected 1 0 000111", tmo_flag, er, rd); else passed++;
    r_ov = 0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) smem[i] = '0;
    test_reset();
    test_store();
    test_load_wait();
    test_aw_before_w();
    test_slverr_hold();
    test_reset_mid();
    test_random();
`ifdef IRIS_AXIL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
